// File: rtl/key_debounce_pkg.sv
// Shared types and default timing for the pushbutton debouncer.
// Defaults assume a 50 MHz clock.
package key_debounce_pkg;

  typedef enum logic [1:0] {
    S_RELEASED    = 2'd0,
    S_PRESS_CHK   = 2'd1,
    S_PRESSED     = 2'd2,
    S_RELEASE_CHK = 2'd3
  } state_t;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 32'd500000;
  localparam int unsigned DEF_REPEAT_DELAY    = 32'd25000000;
  localparam int unsigned DEF_REPEAT_PERIOD   = 32'd5000000;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
// The reset value is a parameter so an idle input level can be chosen.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Metastability filter: two back-to-back flops
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/key_debounce.sv
// Pushbutton debouncer with press/release pulses, debounced level and
// optional auto-repeat while the key is held.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_key_n,
  input  logic i_repeat_en,
  output logic o_press,
  output logic o_release,
  output logic o_level,
  output logic o_repeat
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 32'd1);
  localparam int RPT_W = $clog2(max_u(REPEAT_DELAY, REPEAT_PERIOD) + 32'd1);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 32'd1);
  localparam logic [RPT_W-1:0] RD_LAST = RPT_W'(REPEAT_DELAY - 32'd1);
  localparam logic [RPT_W-1:0] RP_LAST = RPT_W'(REPEAT_PERIOD - 32'd1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [RPT_W-1:0] r_rpt_cnt;
  logic             r_first_done;
  logic             r_press;
  logic             r_release;
  logic             r_level;
  logic             r_repeat;

  logic             w_key_n_sync;
  logic             w_key;
  logic [RPT_W-1:0] w_rpt_last;
  logic             w_rpt_hit;

  // Synchronizer idles at 1 so reset looks like a released key
  sync_2ff #(
    .RST_VAL (1'b1)
  ) u_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_key_n),
    .o_q     (w_key_n_sync)
  );

  assign w_key = ~w_key_n_sync;

  // Repeat threshold: long initial delay, then the shorter period
  always_comb begin
    w_rpt_last = RD_LAST;
    if (r_first_done) begin
      w_rpt_last = RP_LAST;
    end else begin
      w_rpt_last = RD_LAST;
    end
  end

  assign w_rpt_hit = (r_rpt_cnt == w_rpt_last);

  // Debounce FSM with registered pulse/level outputs and repeat timer
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_RELEASED;
      r_cnt        <= '0;
      r_rpt_cnt    <= '0;
      r_first_done <= 1'b0;
      r_press      <= 1'b0;
      r_release    <= 1'b0;
      r_level      <= 1'b0;
      r_repeat     <= 1'b0;
    end else begin
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_repeat  <= 1'b0;
      case (r_state)
        S_RELEASED: begin
          r_level <= 1'b0;
          r_cnt   <= '0;
          if (w_key) begin
            r_state <= S_PRESS_CHK;
          end else begin
            r_state <= S_RELEASED;
          end
        end
        S_PRESS_CHK: begin
          if (!w_key) begin
            r_state <= S_RELEASED;
            r_cnt   <= '0;
          end else if (r_cnt == DB_LAST) begin
            r_state      <= S_PRESSED;
            r_cnt        <= '0;
            r_press      <= 1'b1;
            r_level      <= 1'b1;
            r_rpt_cnt    <= '0;
            r_first_done <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1'b1);
          end
        end
        S_PRESSED: begin
          if (!w_key) begin
            // Repeat timer freezes while a possible release is qualified
            r_state <= S_RELEASE_CHK;
            r_cnt   <= '0;
          end else if (!i_repeat_en) begin
            r_rpt_cnt    <= '0;
            r_first_done <= 1'b0;
          end else if (w_rpt_hit) begin
            // Hold at threshold rather than emit a press adjacent to another
            if (!r_press) begin
              r_press      <= 1'b1;
              r_repeat     <= 1'b1;
              r_rpt_cnt    <= '0;
              r_first_done <= 1'b1;
            end else begin
              r_rpt_cnt <= r_rpt_cnt;
            end
          end else begin
            r_rpt_cnt <= r_rpt_cnt + RPT_W'(1'b1);
          end
        end
        S_RELEASE_CHK: begin
          if (w_key) begin
            // Glitch rejected: the returning sample counts toward repeat timing
            r_state <= S_PRESSED;
            r_cnt   <= '0;
            if (!i_repeat_en) begin
              r_rpt_cnt    <= '0;
              r_first_done <= 1'b0;
            end else if (!w_rpt_hit) begin
              r_rpt_cnt <= r_rpt_cnt + RPT_W'(1'b1);
            end else begin
              r_rpt_cnt <= r_rpt_cnt;
            end
          end else if (r_cnt == DB_LAST) begin
            r_state      <= S_RELEASED;
            r_cnt        <= '0;
            r_release    <= 1'b1;
            r_level      <= 1'b0;
            r_rpt_cnt    <= '0;
            r_first_done <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1'b1);
            if (!i_repeat_en) begin
              r_rpt_cnt    <= '0;
              r_first_done <= 1'b0;
            end else begin
              r_rpt_cnt <= r_rpt_cnt;
            end
          end
        end
        default: begin
          r_state      <= S_RELEASED;
          r_cnt        <= '0;
          r_rpt_cnt    <= '0;
          r_first_done <= 1'b0;
          r_level      <= 1'b0;
        end
      endcase
    end
  end

  assign o_press   = r_press;
  assign o_release = r_release;
  assign o_level   = r_level;
  assign o_repeat  = r_repeat;

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10,
// REPEAT_PERIOD=3; expected pulses are queued with the edge that produces them.
module tb_key_debounce;

  logic clk = 1'b0;
  logic i_rst_n;
  logic i_key_n;
  logic i_repeat_en;
  logic o_press;
  logic o_release;
  logic o_level;
  logic o_repeat;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int   cyc;
    logic press;
    logic rel;
    logic rpt;
    logic level;
  } ev_t;

  ev_t exp_q[$];

  key_debounce #(
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (10),
    .REPEAT_PERIOD   (3)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (i_rst_n),
    .i_key_n     (i_key_n),
    .i_repeat_en (i_repeat_en),
    .o_press     (o_press),
    .o_release   (o_release),
    .o_level     (o_level),
    .o_repeat    (o_repeat)
  );

  always #5 clk = ~clk;

  // Edge counter: after posedge number E, cyc == E
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_ev(input int c, input logic p, input logic r, input logic rp, input logic lv);
    ev_t e;
    e.cyc = c; e.press = p; e.rel = r; e.rpt = rp; e.level = lv;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic until_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: every pulse must match the head of the expectation queue
  always @(negedge clk) begin
    ev_t e;
    if (o_press || o_release || o_repeat) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pulse_unexpected: cycle %0d press=%b release=%b repeat=%b level=%b, none expected",
                 cyc, o_press, o_release, o_repeat, o_level);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.press !== o_press || e.rel !== o_release ||
            e.rpt !== o_repeat || e.level !== o_level) begin
          errors++;
          $display("FAIL pulse_check: got cycle %0d press=%b release=%b repeat=%b level=%b, expected cycle %0d press=%b release=%b repeat=%b level=%b",
                   cyc, o_press, o_release, o_repeat, o_level,
                   e.cyc, e.press, e.rel, e.rpt, e.level);
        end
      end
    end else if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
      checks++;
      errors++;
      e = exp_q.pop_front();
      $display("FAIL pulse_missing: expected press=%b release=%b repeat=%b at cycle %0d, none by cycle %0d",
               e.press, e.rel, e.rpt, e.cyc, cyc);
    end
  end

  initial begin
    int k;
    int p;
    int t;
    i_rst_n     = 1'b0;
    i_key_n     = 1'b1;
    i_repeat_en = 1'b0;
    tick(3);
    check("reset_outputs", {o_press, o_release, o_level, o_repeat}, 4'b0000);
    i_rst_n = 1'b1;
    tick(3);

    // Clean press: key low before edge k -> press at k+6
    k = cyc + 1;
    i_key_n = 1'b0;
    push_ev(k + 6, 1'b1, 1'b0, 1'b0, 1'b1);
    until_cyc(k + 5);
    check("level_before_press", {3'b000, o_level}, 4'b0000);
    until_cyc(k + 6);
    check("level_after_press", {3'b000, o_level}, 4'b0001);
    tick(6);

    // Clean release: key high before edge k -> release at k+6
    k = cyc + 1;
    i_key_n = 1'b1;
    push_ev(k + 6, 1'b0, 1'b1, 1'b0, 1'b0);
    until_cyc(k + 5);
    check("level_before_release", {3'b000, o_level}, 4'b0001);
    until_cyc(k + 6);
    check("level_after_release", {3'b000, o_level}, 4'b0000);
    tick(6);

    // Bounce: low 3, high 1, low again -> single press 6 edges after last low edge
    i_key_n = 1'b0;
    tick(3);
    i_key_n = 1'b1;
    tick(1);
    k = cyc + 1;
    i_key_n = 1'b0;
    push_ev(k + 6, 1'b1, 1'b0, 1'b0, 1'b1);
    until_cyc(k + 12);
    k = cyc + 1;
    i_key_n = 1'b1;
    push_ev(k + 6, 1'b0, 1'b1, 1'b0, 1'b0);
    until_cyc(k + 10);

    // Auto-repeat: first at P+10, then every 3, six repeats before release
    i_repeat_en = 1'b1;
    k = cyc + 1;
    i_key_n = 1'b0;
    p = k + 6;
    push_ev(p, 1'b1, 1'b0, 1'b0, 1'b1);
    push_ev(p + 10, 1'b1, 1'b0, 1'b1, 1'b1);
    push_ev(p + 13, 1'b1, 1'b0, 1'b1, 1'b1);
    push_ev(p + 16, 1'b1, 1'b0, 1'b1, 1'b1);
    push_ev(p + 19, 1'b1, 1'b0, 1'b1, 1'b1);
    push_ev(p + 22, 1'b1, 1'b0, 1'b1, 1'b1);
    push_ev(p + 25, 1'b1, 1'b0, 1'b1, 1'b1);
    until_cyc(p + 24);
    i_key_n = 1'b1;
    push_ev(p + 31, 1'b0, 1'b1, 1'b0, 1'b0);
    until_cyc(p + 36);

    // Release glitch of 2 cycles: repeats shifted by 2, no release
    k = cyc + 1;
    i_key_n = 1'b0;
    p = k + 6;
    push_ev(p, 1'b1, 1'b0, 1'b0, 1'b1);
    push_ev(p + 12, 1'b1, 1'b0, 1'b1, 1'b1);
    push_ev(p + 15, 1'b1, 1'b0, 1'b1, 1'b1);
    push_ev(p + 18, 1'b1, 1'b0, 1'b1, 1'b1);
    until_cyc(p + 2);
    i_key_n = 1'b1;
    until_cyc(p + 4);
    i_key_n = 1'b0;
    until_cyc(p + 6);
    check("level_during_glitch", {3'b000, o_level}, 4'b0001);
    until_cyc(p + 18);
    i_key_n = 1'b1;
    push_ev(p + 25, 1'b0, 1'b1, 1'b0, 1'b0);
    until_cyc(p + 30);

    // Reset mid-hold: outputs clear at once, new press after full debounce
    i_repeat_en = 1'b0;
    k = cyc + 1;
    i_key_n = 1'b0;
    p = k + 6;
    push_ev(p, 1'b1, 1'b0, 1'b0, 1'b1);
    until_cyc(p + 3);
    check("level_before_reset", {3'b000, o_level}, 4'b0001);
    i_rst_n = 1'b0;
    #1;
    check("outputs_in_reset", {o_press, o_release, o_level, o_repeat}, 4'b0000);
    tick(2);
    i_rst_n = 1'b1;
    t = cyc;
    push_ev(t + 7, 1'b1, 1'b0, 1'b0, 1'b1);
    until_cyc(t + 6);
    check("level_after_reset_hold", {3'b000, o_level}, 4'b0000);
    until_cyc(t + 9);
    i_key_n = 1'b1;
    push_ev(t + 16, 1'b0, 1'b1, 1'b0, 1'b0);
    until_cyc(t + 22);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_empty: %0d expected pulses never seen, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at cycle %0d, required completion", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000, giving the stable-sample count that accepts a press or release (10 ms at 50 MHz).
REQ-002 SHALL have parameter REPEAT_DELAY, default 25000000, giving the held cycles before the first auto-repeat (0.5 s).
REQ-003 SHALL have parameter REPEAT_PERIOD, default 5000000, giving the cycles between subsequent auto-repeats (0.1 s).
REQ-004 SHALL have port i_clk, input, width 1: clock.
REQ-005 SHALL have port i_rst_n, input, width 1: reset, asynchronous, active-low.
REQ-006 SHALL have port i_key_n, input, width 1: raw board pushbutton, active-low, asynchronous to i_clk, bouncing.
REQ-007 SHALL have port i_repeat_en, input, width 1: enables auto-repeat while held.
REQ-008 SHALL have port o_press, output, width 1: one-cycle pulse on accepted press and on each auto-repeat; drives downstream i_start.
REQ-009 SHALL have port o_release, output, width 1: one-cycle pulse on accepted release.
REQ-010 SHALL have port o_level, output, width 1: debounced level, 1 = pressed.
REQ-011 SHALL have port o_repeat, output, width 1: one-cycle pulse coincident with auto-repeat o_press pulses only.

Function
REQ-012 SHALL pass i_key_n through a 2-flop synchronizer, then invert it to key_s (1 = pressed).
REQ-013 SHALL implement FSM states S_RELEASED, S_PRESS_CHK, S_PRESSED and S_RELEASE_CHK.
REQ-014 S_RELEASED: key_s=1 -> S_PRESS_CHK, with cnt=0.
REQ-015 S_PRESS_CHK: key_s=0 -> S_RELEASED, with no pulse (bounce rejected); otherwise cnt+1; at cnt==DEBOUNCE_CYCLES-1 with key_s=1 -> S_PRESSED, o_press=1 for one cycle, o_level=1, repeat counter cleared, first-repeat flag cleared.
REQ-016 Latency: i_key_n low from before edge k and held stable SHALL give o_press high in exactly the cycle after edge k+DEBOUNCE_CYCLES+2.
REQ-017 S_PRESSED: key_s=0 -> S_RELEASE_CHK, with cnt=0 and the repeat counter frozen.
REQ-018 S_RELEASE_CHK: key_s=1 -> S_PRESSED, with no pulse; the repeat counter resumes from its frozen value.
REQ-019 S_RELEASE_CHK: at cnt==DEBOUNCE_CYCLES-1 with key_s=0 -> S_RELEASED, o_release=1 for one cycle, o_level=0.
REQ-020 Auto-repeat: in S_PRESSED with key_s=1 and i_repeat_en=1, rpt_cnt SHALL increment every cycle.
REQ-021 Auto-repeat: at rpt_cnt==REPEAT_DELAY-1 (first repeat) or REPEAT_PERIOD-1 (later repeats), o_press=1 and o_repeat=1 for one cycle, rpt_cnt=0, first-repeat flag set.
REQ-022 Deasserting i_repeat_en mid-hold SHALL clear rpt_cnt and the first-repeat flag; re-asserting restarts the REPEAT_DELAY timing.
REQ-023 Counter widths SHALL be $clog2(param+1); counters SHALL be cleared on state entry and SHALL never wrap.
REQ-024 o_press and o_release SHALL never be high in the same cycle; no two o_press pulses SHALL be adjacent.
REQ-025 All outputs SHALL be registered.

Reset
REQ-026 Asserting i_rst_n=0 SHALL immediately force state S_RELEASED, cnt=0, rpt_cnt=0, and o_press, o_release, o_level, o_repeat=0.
REQ-027 Asserting i_rst_n=0 SHALL force the synchronizer flops to 1 (released).
REQ-028 A key held through reset deassertion SHALL produce one normal o_press after full debounce; reset mid-hold SHALL produce no o_release.

Structure
REQ-029 Package key_debounce_pkg SHALL hold the FSM state enum typedef and the default values of the three parameters.
REQ-030 The synchronizer SHALL be sub-module sync_2ff (reset value parameterised); the FSM, counters and repeat logic SHALL be in key_debounce.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
REQ-031 Clean press: i_key_n low before edge 0, held -> o_press high only in the cycle after edge 6; o_level=1 from the same edge.
REQ-032 Bounce: i_key_n low 3 cycles, high 1 cycle, low again -> no o_press until 4+ stable samples after the last edge; exactly one pulse.
REQ-033 Release: after an accepted press, i_key_n high and held -> o_release one cycle after edge r+6; o_level=0.
REQ-034 Auto-repeat: i_repeat_en=1, key held 30 cycles after press -> o_repeat/o_press pulses 10 cycles after press, then every 3 cycles (6 repeats total).
REQ-035 Release glitch: 2-cycle high glitch during hold -> no o_release, o_level stays 1, repeat timing delayed by the glitch length only.
REQ-036 Reset mid-hold: i_rst_n low for 2 cycles while pressed -> all outputs 0 at once; key still held -> one new o_press after debounce.
